reg_read_cycle: RTL and testbench

- Read end of the writeback path: it holds the 32-entry integer register file and consumes the writeback stage's result and valid signals.
- Each cycle it reads the decode-stage source operands, forwarding a same-cycle writeback value when the register matches, and registers the operands into the D->E pipeline register.
- It also keeps the retired-instruction counter, driven by the writeback valid signal.
- It sits between decode and execute, with the write port driven directly by the writeback stage.

---
 rtl/reg_read_cycle_if.sv | 40 ++++
 rtl/reg_read_cycle.sv | 96 +++++++++
 tb/tb_reg_read_cycle.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/reg_read_cycle_if.sv
// Decode/writeback inputs and E-stage outputs of the register read cycle.
// The master drives the WB/decode side; the slave is the read-cycle block.
interface reg_read_cycle_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic            RegWriteW;
  logic            insn_vldW;
  logic [4:0]      RdW;
  logic [XLEN-1:0] ResultW;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [4:0]      RdD;
  logic            insn_vldD;
  logic            StallE;
  logic            FlushE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [4:0]      Rs1E;
  logic [4:0]      Rs2E;
  logic [4:0]      RdE;
  logic            insn_vldE;
  logic [CNT_W-1:0] instret;

  modport master (
    output RegWriteW, insn_vldW, RdW, ResultW,
    output Rs1D, Rs2D, RdD, insn_vldD,
    output StallE, FlushE,
    input  RD1E, RD2E, Rs1E, Rs2E, RdE,
    input  insn_vldE, instret
  );

  modport slave (
    input  RegWriteW, insn_vldW, RdW, ResultW,
    input  Rs1D, Rs2D, RdD, insn_vldD,
    input  StallE, FlushE,
    output RD1E, RD2E, Rs1E, Rs2E, RdE,
    output insn_vldE, instret
  );
endinterface

// File: rtl/reg_read_cycle.sv
// Integer register file with WB->D bypass, D->E pipeline register
// and retired-instruction counter.
module reg_read_cycle #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input logic clk,
  input logic rst,
  reg_read_cycle_if.slave bus
);

  logic [XLEN-1:0]  regs [NREG];
  logic             we;
  logic [XLEN-1:0]  rd1;
  logic [XLEN-1:0]  rd2;

  logic [XLEN-1:0]  rd1_q;
  logic [XLEN-1:0]  rd2_q;
  logic [4:0]       rs1_q;
  logic [4:0]       rs2_q;
  logic [4:0]       rd_q;
  logic             vld_q;
  logic [CNT_W-1:0] cnt_q;

  assign we = bus.RegWriteW & bus.insn_vldW
            & (bus.RdW != 5'd0);

  // x0 never gets written, so its entry stays at its reset zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (we) begin
      regs[bus.RdW] <= bus.ResultW;
    end
  end

  always_comb begin
    rd1 = regs[bus.Rs1D];
    if (bus.Rs1D == 5'd0)
      rd1 = '0;
    else if (we && bus.RdW == bus.Rs1D)
      rd1 = bus.ResultW;
  end

  always_comb begin
    rd2 = regs[bus.Rs2D];
    if (bus.Rs2D == 5'd0)
      rd2 = '0;
    else if (we && bus.RdW == bus.Rs2D)
      rd2 = bus.ResultW;
  end

  // flush outranks stall; a stalled stage keeps stale operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q <= '0;
      rd2_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else if (bus.FlushE) begin
      rd1_q <= '0;
      rd2_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else if (!bus.StallE) begin
      rd1_q <= rd1;
      rd2_q <= rd2;
      rs1_q <= bus.Rs1D;
      rs2_q <= bus.Rs2D;
      rd_q  <= bus.RdD;
      vld_q <= bus.insn_vldD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (bus.insn_vldW)
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.RD1E      = rd1_q;
  assign bus.RD2E      = rd2_q;
  assign bus.Rs1E      = rs1_q;
  assign bus.Rs2E      = rs2_q;
  assign bus.RdE       = rd_q;
  assign bus.insn_vldE = vld_q;
  assign bus.instret   = cnt_q;

endmodule

// File: tb/tb_reg_read_cycle.sv
// Directed bench for reg_read_cycle: reset, bypass, stall/flush,
// qualified writes and retired-instruction counter.
module tb_reg_read_cycle;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  reg_read_cycle_if #(.XLEN(32), .CNT_W(64)) bus ();

  reg_read_cycle #(
    .XLEN(32), .NREG(32), .CNT_W(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic w, input logic v,
                    input logic [4:0] rd,
                    input logic [31:0] res);
    bus.RegWriteW = w;
    bus.insn_vldW = v;
    bus.RdW       = rd;
    bus.ResultW   = res;
  endtask

  task automatic dec(input logic [4:0] r1,
                     input logic [4:0] r2,
                     input logic [4:0] rd,
                     input logic v);
    bus.Rs1D      = r1;
    bus.Rs2D      = r2;
    bus.RdD       = rd;
    bus.insn_vldD = v;
  endtask

  initial begin
    wb(0, 0, 0, 0);
    dec(0, 0, 0, 0);
    bus.StallE = 0;
    bus.FlushE = 0;
    step();
    check("rst_instret", bus.instret, 64'd0);
    check("rst_rd1e", bus.RD1E, 64'd0);
    step();
    rst = 1'b0;

    // reset then read
    dec(5, 0, 0, 0);
    step();
    check("rd_x5_rd1e", bus.RD1E, 64'd0);
    check("rd_x5_rd2e", bus.RD2E, 64'd0);
    check("rd_x5_vld", bus.insn_vldE, 64'd0);
    check("rd_x5_cnt", bus.instret, 64'd0);
    check("rd_x5_rs1e", bus.Rs1E, 64'd5);

    // write x3 then read it
    wb(1, 1, 3, 32'hDEADBEEF);
    dec(0, 0, 0, 0);
    step();
    check("wr_x3_cnt", bus.instret, 64'd1);
    wb(0, 0, 0, 0);
    dec(3, 0, 9, 1);
    step();
    check("rd_x3", bus.RD1E, 64'hDEADBEEF);
    check("rd_x3_rde", bus.RdE, 64'd9);
    check("rd_x3_vld", bus.insn_vldE, 64'd1);

    // same-cycle bypass to both operands
    wb(1, 1, 7, 32'h12345678);
    dec(7, 7, 1, 1);
    step();
    check("byp_rd1", bus.RD1E, 64'h12345678);
    check("byp_rd2", bus.RD2E, 64'h12345678);
    check("byp_cnt", bus.instret, 64'd2);

    // write to x0 is discarded, read of x0 gives 0
    wb(1, 1, 0, 32'hFFFF_FFFF);
    dec(0, 0, 0, 1);
    step();
    check("x0_rd1", bus.RD1E, 64'd0);
    check("x0_rd2", bus.RD2E, 64'd0);
    check("x0_cnt", bus.instret, 64'd3);
    wb(0, 0, 0, 0);
    dec(0, 7, 0, 1);
    step();
    check("x0_after", bus.RD1E, 64'd0);
    check("x7_kept", bus.RD2E, 64'h12345678);

    // stall holds, flush wins, stalled WB still lands
    wb(1, 1, 10, 32'hA);
    dec(0, 0, 0, 0);
    step();
    wb(0, 0, 0, 0);
    dec(10, 0, 2, 1);
    step();
    check("cap_a", bus.RD1E, 64'hA);
    bus.StallE = 1;
    wb(1, 1, 11, 32'hBB);
    dec(3, 7, 4, 1);
    step();
    check("stall_rd1", bus.RD1E, 64'hA);
    check("stall_rs1", bus.Rs1E, 64'd10);
    check("stall_rde", bus.RdE, 64'd2);
    check("stall_cnt", bus.instret, 64'd5);
    wb(0, 0, 0, 0);
    bus.FlushE = 1;
    step();
    check("flush_rd1", bus.RD1E, 64'd0);
    check("flush_rd2", bus.RD2E, 64'd0);
    check("flush_rs1", bus.Rs1E, 64'd0);
    check("flush_rde", bus.RdE, 64'd0);
    check("flush_vld", bus.insn_vldE, 64'd0);
    bus.StallE = 0;
    bus.FlushE = 0;
    dec(11, 0, 0, 1);
    step();
    check("stall_wr", bus.RD1E, 64'hBB);

    // unqualified write: no bypass, no write, no count
    wb(1, 0, 4, 32'h55);
    dec(4, 0, 0, 1);
    step();
    check("q_byp", bus.RD1E, 64'd0);
    check("q_cnt", bus.instret, 64'd5);
    wb(0, 0, 0, 0);
    step();
    check("q_reg", bus.RD1E, 64'd0);

    // 10 cycles toggling retire
    for (int i = 0; i < 10; i++) begin
      bus.insn_vldW = (i % 2 == 0);
      step();
    end
    bus.insn_vldW = 0;
    check("tog_cnt", bus.instret, 64'd10);

    // wrap from all-ones
    @(negedge clk);
    force dut.cnt_q = '1;
    #1;
    release dut.cnt_q;
    check("wrap_pre", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    bus.insn_vldW = 1;
    step();
    check("wrap", bus.instret, 64'd0);
    step();
    check("wrap_inc", bus.instret, 64'd1);

    // async reset mid-sequence
    #2;
    rst = 1'b1;
    #1;
    check("arst_cnt", bus.instret, 64'd0);
    check("arst_rd1", bus.RD1E, 64'd0);
    wb(0, 0, 0, 0);
    step();
    rst = 1'b0;
    dec(3, 11, 0, 1);
    step();
    check("arst_x3", bus.RD1E, 64'd0);
    check("arst_x11", bus.RD2E, 64'd0);
    check("arst_vld", bus.insn_vldE, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
